fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage with a direct-mapped branch target buffer (BTB).
// Each cycle the current PC is looked up in the BTB. A hit with a counter in
// a taken state predicts the stored target. Otherwise the next sequential PC
// (pc + 4, wrapping at 12 bits) is predicted. The next PC is chosen from
// halt, redirect, stall and prediction, in that priority order. A sticky HALT
// state freezes the PC until reset.
//
// Ports
//   CLK           sole clock, rising edge
//   RSTn          synchronous active-low reset
//   stall_i       hold PC and the IF/ID latch
//   redirect_i    restart fetch at redirectPc_i (overrides stall)
//   redirectPc_i  corrected PC
//   halt_i        halt confirmed downstream; enter HALT
//   upd_i         branch resolution update strobe
//   updPc_i       PC of the resolved branch
//   updTaken_i    resolved direction
//   updTarget_i   resolved target
//   imemAddr_o    instruction memory address (registered PC)
//   pc_o          PC of the slot being fetched (registered PC)
//   branchPc_o    predicted next PC, zero-extended to 32 bits
//   bpr_o         predicted-taken flag
//   flush_o       current fetch slot is invalid
//   latchn_o      IF/ID latch enable, active-low (0 = capture)
//------------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [11:0] redirectPc_i,
  input  logic        halt_i,
  input  logic        upd_i,
  input  logic [11:0] updPc_i,
  input  logic        updTaken_i,
  input  logic [11:0] updTarget_i,
  output logic [11:0] imemAddr_o,
  output logic [11:0] pc_o,
  output logic [31:0] branchPc_o,
  output logic        bpr_o,
  output logic        flush_o,
  output logic        latchn_o
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 10 - IDX_W;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [11:0]       r_pc;

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
  logic [11:0]            r_target [BTB_ENTRIES];
  logic [1:0]             r_ctr    [BTB_ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup on the current PC (pre-edge BTB contents)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_lkIdx;
  logic [TAG_W-1:0] w_lkTag;
  logic             w_lkHit;
  logic             w_bpr;
  logic [11:0]      w_pcPlus4;
  logic [11:0]      w_predPc;

  assign w_lkIdx   = r_pc[IDX_W+1:2];
  assign w_lkTag   = r_pc[11:IDX_W+2];
  assign w_lkHit   = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
  // Gated by RSTn so no prediction is reported while reset is held.
  assign w_bpr     = RSTn & w_lkHit & r_ctr[w_lkIdx][1];
  assign w_pcPlus4 = r_pc + 12'd4;
  assign w_predPc  = w_bpr ? r_target[w_lkIdx] : w_pcPlus4;

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_upIdx;
  logic [TAG_W-1:0] w_upTag;
  logic             w_upHit;
  logic [1:0]       w_upCtr;
  logic [1:0]       w_ctrNext;
  logic             w_unused;

  assign w_upIdx = updPc_i[IDX_W+1:2];
  assign w_upTag = updPc_i[11:IDX_W+2];
  assign w_upHit = r_valid[w_upIdx] && (r_tag[w_upIdx] == w_upTag);
  assign w_upCtr = r_ctr[w_upIdx];

  // Byte offset of the branch PC does not take part in indexing or tagging.
  assign w_unused = ^updPc_i[1:0];

  // Two-bit saturating counter step.
  always_comb begin
    w_ctrNext = w_upCtr;
    if (updTaken_i) begin
      if (w_upCtr != 2'b11) w_ctrNext = w_upCtr + 2'd1;
    end else begin
      if (w_upCtr != 2'b00) w_ctrNext = w_upCtr - 2'd1;
    end
  end

  // Valid bits are the only BTB state that needs reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_valid <= '0;
    end else if (upd_i && (w_upHit || updTaken_i)) begin
      r_valid[w_upIdx] <= 1'b1;
    end
  end

  // Tag, target and counter storage; meaningless while the entry is invalid.
  always_ff @(posedge CLK) begin
    if (RSTn && upd_i) begin
      if (w_upHit) begin
        r_ctr[w_upIdx] <= w_ctrNext;
        if (updTaken_i) r_target[w_upIdx] <= updTarget_i;
      end else if (updTaken_i) begin
        r_tag[w_upIdx]    <= w_upTag;
        r_target[w_upIdx] <= updTarget_i;
        r_ctr[w_upIdx]    <= 2'b10;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RUN/HALT state machine and PC register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state <= S_RUN;
      r_pc    <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (halt_i) begin
            r_state <= S_HALT;
          end else if (redirect_i) begin
            r_pc <= redirectPc_i;
          end else if (!stall_i) begin
            r_pc <= w_predPc;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imemAddr_o = r_pc;
  assign pc_o       = r_pc;
  assign branchPc_o = {20'b0, w_predPc};
  assign bpr_o      = w_bpr;
  assign flush_o    = ~RSTn | redirect_i | halt_i | (r_state == S_HALT);
  // In HALT the latch keeps capturing so flushed slots propagate.
  assign latchn_o   = RSTn & (r_state == S_RUN) & stall_i & ~redirect_i & ~halt_i;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int N = 16;

  logic        CLK = 0;
  logic        RSTn, stall_i, redirect_i, halt_i, upd_i, updTaken_i;
  logic [11:0] redirectPc_i, updPc_i, updTarget_i;
  logic [11:0] imemAddr_o, pc_o;
  logic [31:0] branchPc_o;
  logic        bpr_o, flush_o, latchn_o;

  fetch_unit #(.BTB_ENTRIES(N)) dut (
    .CLK(CLK), .RSTn(RSTn), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirectPc_i(redirectPc_i), .halt_i(halt_i), .upd_i(upd_i),
    .updPc_i(updPc_i), .updTaken_i(updTaken_i), .updTarget_i(updTarget_i),
    .imemAddr_o(imemAddr_o), .pc_o(pc_o), .branchPc_o(branchPc_o),
    .bpr_o(bpr_o), .flush_o(flush_o), .latchn_o(latchn_o));

  always #5 CLK = ~CLK;

  typedef struct {
    int pc;
    int bpr;
    longint bpc;
    int flush;
    int latchn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: BTB remembers the full PC of the branch per slot.
  bit m_v[N];
  int m_bpc[N];
  int m_tgt[N];
  int m_ctr[N];
  int m_pc = 0;
  bit m_halted = 0;

  function automatic void predict(input int pc, input bit rst, output int b, output int nxt);
    int idx;
    idx = (pc / 4) % N;
    b = (rst && m_v[idx] && (m_bpc[idx] / 4 == pc / 4) && m_ctr[idx] >= 2) ? 1 : 0;
    nxt = b ? m_tgt[idx] : (pc + 4) % 4096;
  endfunction

  task automatic cyc(input bit rst, input bit st, input bit rd, input int rpc,
                     input bit hl, input bit up, input int upc, input bit tk, input int tgt);
    exp_t e;
    int b, nxt, idx;
    @(negedge CLK);
    RSTn = rst; stall_i = st; redirect_i = rd; redirectPc_i = rpc[11:0];
    halt_i = hl; upd_i = up; updPc_i = upc[11:0]; updTaken_i = tk; updTarget_i = tgt[11:0];
    predict(m_pc, rst, b, nxt);
    if (chk_en) begin
      e.pc = m_pc;
      e.bpr = b;
      e.bpc = longint'(nxt);
      e.flush = (!rst || rd || hl || m_halted) ? 1 : 0;
      e.latchn = (rst && !m_halted && st && !rd && !hl) ? 1 : 0;
      q.push_back(e);
    end
    @(posedge CLK);
    if (!rst) begin
      m_pc = 0; m_halted = 0;
      for (int i = 0; i < N; i++) m_v[i] = 0;
    end else begin
      if (up) begin
        idx = (upc / 4) % N;
        if (m_v[idx] && (m_bpc[idx] / 4 == upc / 4)) begin
          if (tk) begin
            m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
            m_tgt[idx] = tgt;
          end else begin
            m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
          end
        end else if (tk) begin
          m_v[idx] = 1; m_bpc[idx] = upc; m_tgt[idx] = tgt; m_ctr[idx] = 2;
        end
      end
      if (!m_halted) begin
        if (hl) m_halted = 1;
        else if (rd) m_pc = rpc;
        else if (!st) m_pc = nxt;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmp(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a fetch slot; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("pc_o", longint'(pc_o), longint'(e.pc));
        cmp("imemAddr_o", longint'(imemAddr_o), longint'(e.pc));
        cmp("bpr_o", longint'(bpr_o), longint'(e.bpr));
        cmp("branchPc_o", longint'(branchPc_o), e.bpc);
        cmp("flush_o", longint'(flush_o), longint'(e.flush));
        cmp("latchn_o", longint'(latchn_o), longint'(e.latchn));
      end
    end
  end

  initial begin
    int rpc, upc;
    bit rst, st, rd, hl, up, tk;
    // First reset edge brings the DUT to a known state; check from then on.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Sequential fetch, with a taken update at 0x010 -> 0x040 issued early.
    cyc(1, 0, 0, 0, 0, 1, 'h010, 1, 'h040);
    idle(6);
    // Two not-taken updates: counter 2->1->0, then refetch 0x010.
    cyc(1, 0, 0, 0, 0, 1, 'h010, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 'h010, 0, 0);
    cyc(1, 0, 1, 'h010, 0, 0, 0, 0, 0);
    idle(2);
    // Redirect overrides stall.
    cyc(1, 1, 1, 'h100, 0, 0, 0, 0, 0);
    idle(1);
    // Stall three cycles at 0x020.
    cyc(1, 0, 1, 'h020, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Wrap from 0xFFC to 0x000.
    cyc(1, 0, 1, 'hFF4, 0, 0, 0, 0, 0);
    idle(4);
    // Halt at 0x030; redirects and stalls ignored, then reset restarts.
    cyc(1, 0, 1, 'h030, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 'h200, 0, 1, 'h030, 1, 'h300);
    cyc(1, 1, 1, 'h240, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      hl  = ($urandom_range(0, 149) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 4) == 0);
      up  = ($urandom_range(0, 2) == 0);
      tk  = $urandom_range(0, 1);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 255) * 4;
      upc = $urandom_range(0, 255) * 4;
      if (m_halted && $urandom_range(0, 19) == 0) rst = 0;
      cyc(rst, st, rd, rpc, hl, up, upc, tk, $urandom_range(0, 1023) * 4);
    end
    chk_en = 0;
    repeat (3) @(negedge CLK);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
